cpu_bus_sync: RTL and testbench
===============================

CPU_BUS_SYNC -- requirements
Module: cpu_bus_sync

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, which sets the write-FIFO entry count; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter CAPTURE_LO, default 16'h4020; only CPU writes with address >= CAPTURE_LO are queued.
REQ-003 Port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port m2_async, input, 1 bit: raw CPU M2 pin, asynchronous to clk.
REQ-006 Port rw_async, input, 1 bit: raw CPU R/W pin, where 1 = read.
REQ-007 Port addr_async, input, 16 bits: raw CPU address bus.
REQ-008 Port data_async, input, 8 bits: raw CPU data bus.
REQ-009 Port m2_tick, output, 1 bit: one-clk pulse per accepted M2 falling edge, feeding the mapper cycle-IRQ counters.
REQ-010 Port wr_valid, output, 1 bit: the FIFO head holds a queued write.
REQ-011 Port wr_ready, input, 1 bit: the consumer (mapper register file) accepts the head.
REQ-012 Port wr_addr, output, 16 bits: address of the FIFO head.
REQ-013 Port wr_data, output, 8 bits: data of the FIFO head.
REQ-014 Port fifo_level, output, 5 bits: number of occupied entries, 0..FIFO_DEPTH.
REQ-015 Port ovf, output, 1 bit: sticky flag, set when a write was dropped.
REQ-016 Port ovf_clr, input, 1 bit: synchronous clear of ovf.

Function
REQ-017 m2_async SHALL pass through a 2-flop synchronizer, giving m2_s1 then m2_s2.
REQ-018 Capture registers (rw_c, addr_c, data_c) SHALL load the raw bus on every clk while m2_s1=1 and hold their value while m2_s1=0.
REQ-019 An M2 fall SHALL be detected when registered m2_s2 is 1 and current m2_s2 is 0, through states IDLE_LO -> HI (m2_s2=1) -> FALL (one clk) -> IDLE_LO.
REQ-020 m2_tick SHALL be 1 for exactly one clk, in state FALL.
REQ-021 In FALL, if rw_c=0 and addr_c >= CAPTURE_LO (unsigned 16-bit compare), {addr_c, data_c} SHALL be pushed; reads and lower addresses SHALL not be pushed.
REQ-022 Latency SHALL be 4 clk from the first clk edge sampling m2_async=0 to wr_valid=1 with an empty FIFO; m2_tick SHALL assert in clk 3.
REQ-023 A pop SHALL occur on a clk where wr_valid=1 and wr_ready=1; wr_addr and wr_data SHALL hold stable while wr_valid=1 and wr_ready=0.
REQ-024 wr_valid SHALL equal (fifo_level != 0); wr_ready while empty SHALL have no effect.
REQ-025 On a push when full with no pop, the entry SHALL be dropped, ovf set to 1, and FIFO contents unchanged.
REQ-026 On a push when full with a simultaneous pop, the push SHALL be accepted, fifo_level stays FIFO_DEPTH, and ovf is unchanged.
REQ-027 On a simultaneous push and pop at level 1..FIFO_DEPTH-1, the level SHALL be unchanged and order preserved.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH; entries SHALL be delivered in strict FIFO order.
REQ-029 When ovf_clr and an overflow occur in the same clk, the set SHALL win.

Reset
REQ-030 While rst_n=0, m2_s1, m2_s2, the state (IDLE_LO), pointers, fifo_level, ovf, m2_tick and wr_valid SHALL be 0, and capture registers SHALL be 0 with rw_c=1.
REQ-031 A reset mid-cycle or mid-queue SHALL discard all entries; after release, no FALL SHALL occur until m2_s2 has first been seen at 1.

Configuration
REQ-032 With macro M2_FILTER_EN defined, M2 SHALL advance HI and FALL only after m2_s2 differs from the accepted level for 3 consecutive clk, so pulses of 2 clk or less are ignored, and latency in REQ-022 becomes 6 clk (tick at clk 5).
REQ-033 Without M2_FILTER_EN, no filter logic SHALL be present and REQ-022 timing SHALL apply.

Verification
REQ-034 Scenario: a write cycle with addr 16'h8100, data 8'h5A, wr_ready=1 -> m2_tick at clk 3, wr_valid at clk 4 with wr_addr=16'h8100 and wr_data=8'h5A, level returns to 0 next clk.
REQ-035 Scenario: a read of 16'h8000 and a write to 16'h2000 -> m2_tick pulses twice and wr_valid stays 0.
REQ-036 Scenario: wr_ready=0 with 5 writes to 16'h8300..8304 (depth 4) -> level 4, ovf=1, then draining yields 8300..8303 in order.
REQ-037 Scenario: FIFO full with wr_ready=1 on the push clk -> level stays 4 and ovf stays 0; ovf_clr together with an overflow -> ovf=1.
REQ-038 Scenario: rst_n low with 3 queued entries and M2 high -> level 0 and wr_valid 0; the first M2 fall after release is not ticked unless M2 rose after release.
REQ-039 Scenario (M2_FILTER_EN): a 2-clk M2 low glitch -> no m2_tick; a 3-clk low -> one tick.

Source files
------------

// File: rtl/cpu_bus_sync.sv
// cpu_bus_sync: brings the asynchronous CPU bus (M2, R/W, address, data) into
// the clk domain, emits one m2_tick per M2 falling edge and queues CPU writes
// at or above CAPTURE_LO into a small FIFO for the mapper register file.
// Optional macro M2_FILTER_EN adds a 3-clk persistence filter on synchronized M2.
module cpu_bus_sync #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] CAPTURE_LO = 16'h4020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m2_async,
  input  logic        rw_async,
  input  logic [15:0] addr_async,
  input  logic [7:0]  data_async,
  output logic        m2_tick,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [4:0]  fifo_level,
  output logic        ovf,
  input  logic        ovf_clr
);

  localparam int         LP_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] LP_DEPTH = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    HI      = 2'd1,
    FALL    = 2'd2
  } state_t;

  logic             r_m2_s1;
  logic             r_m2_s2;
  logic             r_rw_c;
  logic [15:0]      r_addr_c;
  logic [7:0]       r_data_c;
  logic             w_m2_lvl;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [23:0]      r_mem [FIFO_DEPTH];
  logic [LP_AW-1:0] r_wptr;
  logic [LP_AW-1:0] r_rptr;
  logic [4:0]       r_level;
  logic             r_ovf;
  logic             w_is_write;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_accept;

  // Two-flop synchronizer for the raw M2 pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m2_s1 <= 1'b0;
      r_m2_s2 <= 1'b0;
    end else begin
      r_m2_s1 <= m2_async;
      r_m2_s2 <= r_m2_s1;
    end
  end

  // Track the bus while M2 is high; freeze it once M2 drops so FALL sees stable values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw_c   <= 1'b1;
      r_addr_c <= 16'h0000;
      r_data_c <= 8'h00;
    end else if (r_m2_s1) begin
      r_rw_c   <= rw_async;
      r_addr_c <= addr_async;
      r_data_c <= data_async;
    end
  end

`ifdef M2_FILTER_EN
  logic       r_m2_acc;
  logic [1:0] r_flt_cnt;

  // Accept a new M2 level only after it has persisted for three consecutive clks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m2_acc  <= 1'b0;
      r_flt_cnt <= 2'd0;
    end else if (r_m2_s2 != r_m2_acc) begin
      if (r_flt_cnt == 2'd2) begin
        r_m2_acc  <= r_m2_s2;
        r_flt_cnt <= 2'd0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 2'd1;
      end
    end else begin
      r_flt_cnt <= 2'd0;
    end
  end

  assign w_m2_lvl = ((r_m2_s2 != r_m2_acc) && (r_flt_cnt == 2'd2)) ? r_m2_s2 : r_m2_acc;
`else
  assign w_m2_lvl = r_m2_s2;
`endif

  // Edge-detect FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE_LO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A fall is only recognised after M2 has been seen high, so reset never fakes a tick.
  always_comb begin
    w_state_nxt = r_state;
    m2_tick     = 1'b0;
    case (r_state)
      IDLE_LO: if (w_m2_lvl) w_state_nxt = HI;
      HI:      if (!w_m2_lvl) w_state_nxt = FALL;
      FALL: begin
        m2_tick     = 1'b1;
        w_state_nxt = IDLE_LO;
      end
      default: w_state_nxt = IDLE_LO;
    endcase
  end

  assign w_is_write = !r_rw_c && (r_addr_c >= CAPTURE_LO);
  assign w_push     = (r_state == FALL) && w_is_write;
  assign w_full     = (r_level == LP_DEPTH);
  assign w_pop      = (r_level != 5'd0) && wr_ready;
  assign w_accept   = w_push && (!w_full || w_pop);

  // Queue storage; a full-FIFO push with a pop reuses the slot being vacated.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wptr] <= {r_addr_c, r_data_c};
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= 5'd0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + LP_AW'(1);
      if (w_pop)    r_rptr <= r_rptr + LP_AW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same clk as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign wr_valid   = (r_level != 5'd0);
  assign wr_addr    = r_mem[r_rptr][23:8];
  assign wr_data    = r_mem[r_rptr][7:0];
  assign fifo_level = r_level;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_cpu_bus_sync.sv
// tb_cpu_bus_sync: directed and randomized CPU bus cycles against a queue-based
// reference model of the write FIFO, tick count and sticky overflow flag.
module tb_cpu_bus_sync;

  localparam int          DEPTH  = 4;
  localparam logic [15:0] CAP_LO = 16'h4020;
`ifdef M2_FILTER_EN
  localparam int TICK_CLK = 5;
`else
  localparam int TICK_CLK = 3;
`endif
  localparam int PUSH_CLK = TICK_CLK + 1;

  logic        clk;
  logic        rst_n;
  logic        m2_async;
  logic        rw_async;
  logic [15:0] addr_async;
  logic [7:0]  data_async;
  logic        m2_tick;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  fifo_level;
  logic        ovf;
  logic        ovf_clr;

  int          total;
  int          bad;
  int          tickCount;
  int          expTicks;
  logic [23:0] modelQ [$];
  logic        modelOvf;

  cpu_bus_sync #(
    .FIFO_DEPTH(DEPTH),
    .CAPTURE_LO(CAP_LO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m2_async  (m2_async),
    .rw_async  (rw_async),
    .addr_async(addr_async),
    .data_async(data_async),
    .m2_tick   (m2_tick),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .fifo_level(fifo_level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every tick pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (m2_tick === 1'b1) tickCount++;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseClr();
    ovf_clr = 1'b1;
    waitClk(1);
    ovf_clr = 1'b0;
    modelOvf = 1'b0;
  endtask

  // One complete CPU bus cycle, optionally raising wr_ready / ovf_clr for exactly the push clk.
  task automatic applyStimulus(input logic rw, input logic [15:0] a, input logic [7:0] d,
                               input int hiClks, input int loClks,
                               input bit readyOnPush, input bit clrOnPush);
    bit qualifies;
    bit popNow;
    bit fullNow;
    m2_async   = 1'b1;
    rw_async   = rw;
    addr_async = a;
    data_async = d;
    waitClk(hiClks);
    m2_async = 1'b0;
    for (int k = 1; k <= loClks; k++) begin
      @(negedge clk);
      if (k == PUSH_CLK - 1) begin
        if (readyOnPush) wr_ready = 1'b1;
        if (clrOnPush)   ovf_clr  = 1'b1;
      end else if (k == PUSH_CLK) begin
        if (readyOnPush) wr_ready = 1'b0;
        ovf_clr = 1'b0;
      end
    end
    qualifies = (rw == 1'b0) && (a >= CAP_LO);
    fullNow   = (modelQ.size() == DEPTH);
    popNow    = readyOnPush && (modelQ.size() > 0);
    if (popNow) void'(modelQ.pop_front());
    if (qualifies && (!fullNow || popNow)) modelQ.push_back({a, d});
    if (qualifies && fullNow && !popNow) modelOvf = 1'b1;
    else if (clrOnPush) modelOvf = 1'b0;
    expTicks++;
  endtask

  // Consume entries with random back-pressure, checking head, level and valid every clk.
  task automatic drain(input int budget, input bit stopWhenEmpty);
    for (int c = 0; c < budget; c++) begin
      checkOutput("level", fifo_level, modelQ.size());
      checkOutput("valid", wr_valid, modelQ.size() != 0);
      if (modelQ.size() > 0) begin
        checkOutput("headAddr", wr_addr, modelQ[0][23:8]);
        checkOutput("headData", wr_data, modelQ[0][7:0]);
      end
      if (stopWhenEmpty && modelQ.size() == 0) break;
      wr_ready = 1'($urandom_range(0, 1));
      if (wr_ready && modelQ.size() > 0) void'(modelQ.pop_front());
      @(negedge clk);
    end
    wr_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    int          sel;
    total = 0; bad = 0; tickCount = 0; expTicks = 0; modelOvf = 1'b0;
    rst_n = 1'b0; m2_async = 1'b0; rw_async = 1'b1; addr_async = 16'h0; data_async = 8'h0;
    wr_ready = 1'b0; ovf_clr = 1'b0;
    waitClk(3);
    checkOutput("rstLevel", fifo_level, 0);
    checkOutput("rstValid", wr_valid, 0);
    checkOutput("rstTick", m2_tick, 0);
    checkOutput("rstOvf", ovf, 0);
    rst_n = 1'b1;
    waitClk(4);
    checkOutput("noTickAfterRst", tickCount, 0);

    $display("[TB] single write with consumer ready");
    wr_ready = 1'b1;
    m2_async = 1'b1; rw_async = 1'b0; addr_async = 16'h8100; data_async = 8'h5A;
    waitClk(8);
    m2_async = 1'b0;
    for (int k = 1; k <= PUSH_CLK + 1; k++) begin
      @(negedge clk);
      if (k == TICK_CLK - 1) checkOutput("tickEarly", m2_tick, 0);
      if (k == TICK_CLK) begin
        checkOutput("tickAt", m2_tick, 1);
        checkOutput("validEarly", wr_valid, 0);
      end
      if (k == PUSH_CLK) begin
        checkOutput("tickLate", m2_tick, 0);
        checkOutput("validAt", wr_valid, 1);
        checkOutput("addrAt", wr_addr, 16'h8100);
        checkOutput("dataAt", wr_data, 8'h5A);
        checkOutput("levelAt", fifo_level, 1);
      end
      if (k == PUSH_CLK + 1) begin
        checkOutput("levelPopped", fifo_level, 0);
        checkOutput("validPopped", wr_valid, 0);
      end
    end
    wr_ready = 1'b0;
    expTicks++;
    waitClk(4);
    checkOutput("ticksWrite", tickCount, expTicks);

    $display("[TB] read and low-address write are not queued");
    applyStimulus(1'b1, 16'h8000, 8'h11, 8, PUSH_CLK + 3, 0, 0);
    applyStimulus(1'b0, 16'h2000, 8'h22, 8, PUSH_CLK + 3, 0, 0);
    applyStimulus(1'b0, CAP_LO - 16'd1, 8'h33, 8, PUSH_CLK + 3, 0, 0);
    checkOutput("filterValid", wr_valid, 0);
    checkOutput("filterLevel", fifo_level, 0);
    checkOutput("filterTicks", tickCount, expTicks);

    $display("[TB] overflow with consumer stalled");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 16'h8300 + 16'(i), 8'(8'hA0 + i), 8, PUSH_CLK + 3, 0, 0);
    checkOutput("fullLevel", fifo_level, DEPTH);
    checkOutput("ovfSet", ovf, modelOvf);
    checkOutput("fullHead", wr_addr, modelQ[0][23:8]);
    drain(40, 1);
    checkOutput("ovfSticky", ovf, modelOvf);
    pulseClr();
    checkOutput("ovfCleared", ovf, modelOvf);

    $display("[TB] full FIFO with pop on push clk, clear against overflow");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 16'h8400 + 16'(i), 8'(8'hB0 + i), 8, PUSH_CLK + 3, 0, 0);
    applyStimulus(1'b0, 16'h8404, 8'hB4, 8, PUSH_CLK + 3, 1, 0);
    checkOutput("pushPopLevel", fifo_level, DEPTH);
    checkOutput("pushPopOvf", ovf, modelOvf);
    checkOutput("pushPopHead", wr_addr, modelQ[0][23:8]);
    applyStimulus(1'b0, 16'h8405, 8'hB5, 8, PUSH_CLK + 3, 0, 1);
    checkOutput("setWinsOvf", ovf, modelOvf);
    wr_ready = 1'b1;
    void'(modelQ.pop_front());
    waitClk(1);
    wr_ready = 1'b0;
    checkOutput("threeQueued", fifo_level, modelQ.size());

    $display("[TB] reset mid-queue with M2 high");
    m2_async = 1'b1; rw_async = 1'b0; addr_async = 16'h8600; data_async = 8'hC6;
    waitClk(4);
    rst_n = 1'b0;
    modelQ.delete();
    modelOvf = 1'b0;
    waitClk(1);
    checkOutput("midRstLevel", fifo_level, 0);
    checkOutput("midRstValid", wr_valid, 0);
    checkOutput("midRstOvf", ovf, 0);
    checkOutput("midRstTick", m2_tick, 0);
    m2_async = 1'b0;
    waitClk(2);
    rst_n = 1'b1;
    waitClk(10);
    checkOutput("noFallAfterRst", tickCount, expTicks);
    checkOutput("emptyAfterRst", fifo_level, 0);
    applyStimulus(1'b0, 16'h8500, 8'h77, 8, PUSH_CLK + 3, 0, 0);
    checkOutput("tickAfterRise", tickCount, expTicks);
    drain(20, 1);

    $display("[TB] short M2 low pulses");
    rw_async = 1'b1; addr_async = 16'h0100;
    m2_async = 1'b1;
    waitClk(8);
    m2_async = 1'b0;
    waitClk(2);
    m2_async = 1'b1;
    waitClk(10);
`ifdef M2_FILTER_EN
    checkOutput("glitch2Ignored", tickCount, expTicks);
    m2_async = 1'b0;
    waitClk(3);
    m2_async = 1'b1;
    waitClk(10);
    expTicks++;
    checkOutput("low3Ticks", tickCount, expTicks);
`else
    expTicks++;
    checkOutput("low2Ticks", tickCount, expTicks);
`endif

    $display("[TB] randomized bus traffic");
    for (int r = 0; r < 5; r++) begin
      pulseClr();
      for (int n = 0; n < int'($urandom_range(2, 7)); n++) begin
        sel = int'($urandom_range(0, 3));
        case (sel)
          0:       a = CAP_LO - 16'd1;
          1:       a = CAP_LO;
          2:       a = 16'($urandom);
          default: a = 16'h8000 | 16'($urandom);
        endcase
        applyStimulus(1'($urandom_range(0, 3) == 0), a, 8'($urandom),
                      int'($urandom_range(6, 10)), int'($urandom_range(PUSH_CLK + 2, PUSH_CLK + 5)),
                      1'($urandom_range(0, 1)), 0);
      end
      waitClk(2);
      checkOutput("rndLevel", fifo_level, modelQ.size());
      checkOutput("rndOvf", ovf, modelOvf);
      checkOutput("rndTicks", tickCount, expTicks);
      drain(int'($urandom_range(2, 12)), 0);
    end
    drain(60, 1);
    checkOutput("finalTicks", tickCount, expTicks);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
